dsp_wb_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that shares the single DSP Wishbone slave port between NM bus masters (CPU, DMA, data-acquisition engines).
- Sits between the masters and the DSP slave.
- Holds the grant for a whole cycle, including bursts.
- A bus watchdog terminates a hung slave access with an error to the requesting master.

---
 rtl/dsp_bus_pkg.sv | 15 +
 rtl/rr_priority_picker.sv | 29 ++
 rtl/dsp_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_dsp_wb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_bus_pkg.sv
// Shared Wishbone definitions for the DSP bus fabric: cycle-type codes and
// the arbiter state encoding.
package dsp_bus_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first requester at or above
// ptr, wrapping modulo NM, and returns it one-hot and encoded.
module rr_priority_picker #(
  parameter int NM = 4,
  parameter int PW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] grant,
  output logic [PW-1:0] idx
);

  always_comb begin : pick
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      int unsigned k;
      k = (int'(ptr) + i) % NM;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = PW'(k);
      end
    end
  end

endmodule

// File: rtl/dsp_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the DSP slave port between NM masters,
// with a bus watchdog that aborts hung slave accesses.
module dsp_wb_arbiter
  import dsp_bus_pkg::*;
#(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int NM      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [NM*aw-1:0] m_adr_i,
  input  logic [NM*dw-1:0] m_dat_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM*3-1:0]  m_cti_i,
  input  logic [NM*2-1:0]  m_bte_i,
  output logic [dw-1:0]    m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NM-1:0]    m_rty_o,
  output logic [aw-1:0]    s_adr_o,
  output logic [dw-1:0]    s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic [2:0]       s_cti_o,
  output logic [1:0]       s_bte_o,
  input  logic [dw-1:0]    s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  output logic [NM-1:0]    grant_o,
  output logic             timeout_o
);

  localparam int PW = $clog2(NM);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  arb_state_t    state, state_nx;
  logic [NM-1:0] grant, grant_nx;
  logic [PW-1:0] ptr, ptr_nx, gidx, gidx_nx, ptr_after;
  logic [WW-1:0] wd_cnt, wd_nx;
  logic          wd_err, wd_err_nx, timeout_q;
  logic [NM-1:0] pick_grant;
  logic [PW-1:0] pick_idx;
  logic          own_cyc, own_stb, own_we, live, resp;

  rr_priority_picker #(.NM(NM), .PW(PW)) u_pick (
    .req   (m_cyc_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // AND-OR mux on the one-hot grant; all zero while no master owns the bus
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    for (int unsigned k = 0; k < NM; k++) begin
      if (grant[k]) begin
        s_adr_o = m_adr_i[k*aw +: aw];
        s_dat_o = m_dat_i[k*dw +: dw];
        s_sel_o = m_sel_i[k*4 +: 4];
        s_cti_o = m_cti_i[k*3 +: 3];
        s_bte_o = m_bte_i[k*2 +: 2];
        own_we  = m_we_i[k];
        own_cyc = m_cyc_i[k];
        own_stb = m_stb_i[k];
      end
    end
  end

  assign live      = (state == GRANT);
  assign resp      = s_ack_i | s_err_i | s_rty_i;
  assign s_cyc_o   = live & own_cyc;
  assign s_stb_o   = live & own_cyc & own_stb;
  assign s_we_o    = live & own_cyc & own_we;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = grant & m_cyc_i & {NM{live & s_ack_i}};
  assign m_rty_o   = grant & m_cyc_i & {NM{live & s_rty_i}};
  assign m_err_o   = (grant & m_cyc_i & {NM{live & s_err_i}}) | (grant & {NM{wd_err}});
  assign grant_o   = grant;
  assign timeout_o = timeout_q;
  assign ptr_after = (gidx == PW'(NM - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    ptr_nx    = ptr;
    gidx_nx   = gidx;
    wd_nx     = '0;
    wd_err_nx = 1'b0;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          grant_nx = pick_grant;
          gidx_nx  = pick_idx;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_nx = IDLE;
          grant_nx = '0;
          ptr_nx   = ptr_after;
        end else if (s_stb_o && !resp && TIMEOUT > 0) begin
          // a response in the limit cycle takes the else path and clears the count
          if (wd_cnt == WD_LAST) begin
            state_nx  = ABORT;
            wd_err_nx = 1'b1;
          end else begin
            wd_nx = wd_cnt + 1'b1;
          end
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_nx = IDLE;
          grant_nx = '0;
          ptr_nx   = ptr_after;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      gidx      <= '0;
      wd_cnt    <= '0;
      wd_err    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      ptr       <= ptr_nx;
      gidx      <= gidx_nx;
      wd_cnt    <= wd_nx;
      wd_err    <= wd_err_nx;
      timeout_q <= timeout_q | wd_err_nx;
    end
  end

endmodule

// File: tb/tb_dsp_wb_arbiter.sv
// Self-checking bench for dsp_wb_arbiter: directed arbitration/burst/watchdog
// sequences plus randomized rounds checked against a round-robin order model.
module tb_dsp_wb_arbiter;
  import dsp_bus_pkg::*;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             wb_clk = 1'b0;
  logic             wb_rst;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack_i, s_err_i, s_rty_i;
  logic [NM-1:0]    grant_o;
  logic             timeout_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] adr_m[NM];
  logic [31:0] dat_m[NM];
  logic [3:0]  sel_m[NM];
  logic        we_m[NM];

  dsp_wb_arbiter #(.dw(DW), .aw(AW), .NM(NM), .TIMEOUT(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic cyc, input logic stb, input logic [31:0] adr,
                            input logic we, input logic [3:0] sel, input logic [2:0] cti);
    adr_m[m] = adr;
    dat_m[m] = ~adr;
    sel_m[m] = sel;
    we_m[m]  = we;
    m_adr_i[m*AW +: AW] = adr;
    m_dat_i[m*DW +: DW] = ~adr;
    m_sel_i[m*4 +: 4]   = sel;
    m_cti_i[m*3 +: 3]   = cti;
    m_bte_i[m*2 +: 2]   = 2'b00;
    m_we_i[m]  = we;
    m_cyc_i[m] = cyc;
    m_stb_i[m] = stb;
  endtask

  task automatic clear_inputs();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    clear_inputs();
    step();
    step();
    wb_rst = 1'b0;
  endtask

  // Wait for master m to own the bus, answer after lat wait cycles with the
  // chosen response (0 ack, 1 err, 2 rty), then the master ends its cycle.
  task automatic serve(input int m, input int lat, input logic [31:0] data, input int rsp,
                       output int waited);
    logic [NM-1:0] v;
    v = NM'(1 << m);
    waited = 0;
    while (grant_o == '0 && waited < 20) begin
      step();
      waited++;
    end
    chk("grant", grant_o, v);
    chk("s_cyc", s_cyc_o, 1);
    chk("s_adr", s_adr_o, adr_m[m]);
    chk("s_dat", s_dat_o, dat_m[m]);
    chk("s_sel", s_sel_o, sel_m[m]);
    chk("s_we", s_we_o, we_m[m]);
    for (int i = 0; i < lat; i++) begin
      step();
      chk("no_early_resp", {m_ack_o, m_err_o, m_rty_o}, '0);
    end
    s_dat_i = data;
    s_ack_i = (rsp == 0);
    s_err_i = (rsp == 1);
    s_rty_i = (rsp == 2);
    #1;
    chk("m_ack", m_ack_o, (rsp == 0) ? v : '0);
    chk("m_err", m_err_o, (rsp == 1) ? v : '0);
    chk("m_rty", m_rty_o, (rsp == 2) ? v : '0);
    chk("m_dat", m_dat_o, data);
    step();
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    m_cyc_i[m] = 1'b0;
    m_stb_i[m] = 1'b0;
    #1;
    chk("hold_after_resp", grant_o, v);
    step();
    chk("release_grant", grant_o, '0);
    chk("release_cyc", s_cyc_o, 0);
    chk("no_wd_err", m_err_o, '0);
  endtask

  typedef struct {
    logic [3:0] req;
    int         n;
    int         ord[4];
  } vec_t;

  vec_t tbl[5];
  int   w;
  int   mptr;
  int   order[$];
  logic [3:0] mask;

  initial begin
    tbl[0] = '{4'b1011, 3, '{0, 1, 3, 0}};
    tbl[1] = '{4'b0011, 2, '{0, 1, 0, 0}};
    tbl[2] = '{4'b1111, 4, '{2, 3, 0, 1}};
    tbl[3] = '{4'b0101, 2, '{2, 0, 0, 0}};
    tbl[4] = '{4'b1000, 1, '{3, 0, 0, 0}};

    do_reset();
    chk("rst_grant", grant_o, '0);
    chk("rst_ctrl", {s_cyc_o, s_stb_o, s_we_o}, '0);
    chk("rst_resp", {m_ack_o, m_err_o, m_rty_o}, '0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_adr_dat_sel", {s_adr_o, s_dat_o, s_sel_o}, '0);

    // strobe without cycle must not be arbitrated
    m_stb_i[0] = 1'b1;
    step();
    step();
    chk("stb_no_cyc", grant_o, '0);
    m_stb_i[0] = 1'b0;

    set_master(2, 1, 1, 32'h10, 1'b0, 4'hF, CTI_CLASSIC);
    serve(2, 2, 32'hDEADBEEF, 0, w);
    chk("arb_latency", w, 1);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NM; k++)
        if (tbl[i].req[k]) set_master(k, 1, 1, 32'h1000 + 32'(i*64 + k*4), 1'(k), 4'(k + 1), CTI_CLASSIC);
      for (int j = 0; j < tbl[i].n; j++) begin
        serve(tbl[i].ord[j], j, 32'hA000_0000 + 32'(i*16 + j), 0, w);
        if (i == 0 && j == 0) chk("tbl_latency", w, 1);
      end
    end

    // burst by master 1 while master 0 waits
    set_master(1, 1, 1, 32'h100, 1'b0, 4'hF, CTI_INCR);
    step();
    chk("burst_grant", grant_o, 4'b0010);
    set_master(0, 1, 1, 32'h200, 1'b1, 4'h3, CTI_CLASSIC);
    for (int b = 0; b < 4; b++) begin
      set_master(1, 1, 1, 32'h100 + 32'(b*4), 1'b0, 4'hF, (b == 3) ? CTI_EOB : CTI_INCR);
      step();
      s_ack_i = 1'b1;
      s_dat_i = 32'hB000 + 32'(b);
      #1;
      chk("burst_ack", m_ack_o, 4'b0010);
      chk("burst_adr", s_adr_o, 32'h100 + 32'(b*4));
      chk("burst_cti", s_cti_o, (b == 3) ? CTI_EOB : CTI_INCR);
      chk("burst_dat", m_dat_o, 32'hB000 + 32'(b));
      step();
      s_ack_i = 1'b0;
    end
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    step();
    chk("burst_gap", grant_o, '0);
    step();
    chk("burst_next", grant_o, 4'b0001);
    serve(0, 1, 32'h5555_AAAA, 0, w);

    // response in the very cycle the watchdog would fire wins
    set_master(3, 1, 1, 32'h300, 1'b0, 4'hF, CTI_CLASSIC);
    serve(3, 7, 32'h1234_5678, 0, w);
    chk("limit_no_timeout", timeout_o, 0);

    // hung slave: error pulse 8 cycles after the first strobe cycle
    set_master(3, 1, 1, 32'h304, 1'b0, 4'hF, CTI_CLASSIC);
    step();
    chk("wd_grant", grant_o, 4'b1000);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("wd_err", m_err_o, (c == 8) ? 4'b1000 : 4'b0000);
      chk("wd_cyc", s_cyc_o, (c == 8) ? 1'b0 : 1'b1);
    end
    chk("wd_timeout", timeout_o, 1);
    step();
    chk("wd_pulse_end", m_err_o, '0);
    chk("abort_cyc", {s_cyc_o, s_stb_o}, '0);
    chk("abort_hold", grant_o, 4'b1000);
    s_ack_i = 1'b1;
    #1;
    chk("abort_ignore", m_ack_o, '0);
    s_ack_i = 1'b0;
    m_cyc_i[3] = 1'b0;
    m_stb_i[3] = 1'b0;
    step();
    chk("abort_release", grant_o, '0);
    chk("timeout_sticky", timeout_o, 1);

    // reset mid-burst; pointer must restart at 0
    set_master(2, 1, 1, 32'h400, 1'b0, 4'hF, CTI_CLASSIC);
    serve(2, 0, 32'h0, 0, w);
    set_master(2, 1, 1, 32'h410, 1'b0, 4'hF, CTI_INCR);
    step();
    chk("mid_grant", grant_o, 4'b0100);
    step();
    s_ack_i = 1'b1;
    #1;
    chk("mid_ack", m_ack_o, 4'b0100);
    #2;
    wb_rst = 1'b1;
    #1;
    chk("async_rst", {s_cyc_o, grant_o, m_ack_o}, '0);
    chk("async_rst_to", timeout_o, 0);
    clear_inputs();
    step();
    wb_rst = 1'b0;
    set_master(1, 1, 1, 32'h510, 1'b0, 4'hF, CTI_CLASSIC);
    set_master(3, 1, 1, 32'h530, 1'b0, 4'hF, CTI_CLASSIC);
    serve(1, 1, 32'h11, 0, w);
    serve(3, 1, 32'h33, 0, w);

    // randomized rounds against a rotation-order model
    do_reset();
    mptr = 0;
    for (int r = 0; r < 40; r++) begin
      mask = 4'($urandom_range(1, 15));
      order.delete();
      for (int i = 0; i < NM; i++)
        if (mask[(mptr + i) % NM]) order.push_back((mptr + i) % NM);
      for (int k = 0; k < NM; k++)
        if (mask[k]) set_master(k, 1, 1, $urandom, 1'($urandom_range(0, 1)),
                                4'($urandom_range(1, 15)), CTI_CLASSIC);
      foreach (order[j])
        serve(order[j], $urandom_range(0, 6), $urandom, $urandom_range(0, 2), w);
      mptr = (order[order.size() - 1] + 1) % NM;
    end
    chk("rand_no_timeout", timeout_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
